// File: rtl/sd_fifo_pkg.sv
// Shared helpers for the srdy/drdy "S" FIFO family (head and tail blocks).
// Pointer conversion functions work on any pointer width up to PTR_MAX_W:
// callers zero-extend their pointer into the function and truncate the result
// back to their own width. The zero-extended upper bits stay zero through both
// conversions, so the low bits are correct for any narrower width.
package sd_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 32'd1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits
  // at or above its position.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = '0;
    for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset, clears both stages
//   en    - clock enable; both stages hold while low
//   d     - value from the source clock domain
//   q     - synchronized value, two enabled cycles behind d
module sd_sync2 #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta_r;
  logic [width-1:0] sync_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else if (en) begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/sd_fifo_tail_small.sv
// Read-side controller of an srdy/drdy FIFO built around an external memory
// with one-cycle read latency. Owns the read pointer, issues read strobes and
// addresses, presents read data validity to the consumer and reports usage.
// With async=1 it is the consumer half of a two-clock FIFO (Gray pointers).
// Ports:
//   clk        - consumer clock
//   reset      - asynchronous active-low reset
//   clken      - clock enable; gates every state update and rd_en
//   wrptr_head - write pointer from the head block (Gray when async=1)
//   rdptr_tail - registered read pointer to the head block (Gray when async=1)
//   rd_en      - memory read strobe
//   rd_addr    - memory read address
//   p_srdy     - memory read data valid this cycle
//   p_drdy     - consumer accepts the current word
//   p_usage    - words written but not yet read from memory
module sd_fifo_tail_small
  import sd_fifo_pkg::*;
#(
  parameter int depth = 16,
  parameter int async = 0,
  parameter int asz   = $clog2(depth)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic [asz:0]   wrptr_head,
  output logic [asz:0]   rdptr_tail,
  output logic           rd_en,
  output logic [asz-1:0] rd_addr,
  output logic           p_srdy,
  input  logic           p_drdy,
  output logic [asz:0]   p_usage
);

  localparam int PW = asz + 1;

  logic [asz:0] wrptr_s;
  logic [asz:0] rdptr_r;
  logic [asz:0] rdptr_nxt_s;
  logic [asz:0] tail_r;
  logic [asz:0] tail_nxt_s;
  logic         p_srdy_r;
  logic         p_srdy_nxt_s;
  logic         empty_s;

  generate
    if (async != 0) begin : g_async
      logic [asz:0] wrptr_sync_s;

      sd_sync2 #(.width(PW)) u_sync (
        .clk   (clk),
        .reset (reset),
        .en    (clken),
        .d     (wrptr_head),
        .q     (wrptr_sync_s)
      );

      assign wrptr_s = PW'(gray2bin(PTR_MAX_W'(wrptr_sync_s)));
    end else begin : g_sync
      assign wrptr_s = wrptr_head;
    end
  endgenerate

  // The MSB is a wrap bit, so equal pointers mean empty, never full.
  assign empty_s = (wrptr_s == rdptr_r);

  // Read only when the output slot is free or is being drained this cycle.
  assign rd_en   = clken & ~empty_s & (p_drdy | ~p_srdy_r);
  assign rd_addr = rdptr_r[asz-1:0];
  assign p_usage = wrptr_s - rdptr_r;
  assign p_srdy  = p_srdy_r;

  // Next read pointer, exported pointer and output-valid flag.
  always_comb begin
    rdptr_nxt_s  = rdptr_r;
    tail_nxt_s   = tail_r;
    p_srdy_nxt_s = p_srdy_r;
    if (rd_en) begin
      rdptr_nxt_s  = rdptr_r + {{asz{1'b0}}, 1'b1};
      p_srdy_nxt_s = 1'b1;
    end else if (p_drdy) begin
      p_srdy_nxt_s = 1'b0;
    end else begin
      p_srdy_nxt_s = p_srdy_r;
    end
    // The exported pointer tracks the new rdptr so the head sees the free
    // slot in the same cycle the read pointer moves.
    if (async != 0) begin
      tail_nxt_s = PW'(bin2gray(PTR_MAX_W'(rdptr_nxt_s)));
    end else begin
      tail_nxt_s = rdptr_nxt_s;
    end
  end

  // Read-side state; everything freezes while clken is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdptr_r  <= '0;
      tail_r   <= '0;
      p_srdy_r <= 1'b0;
    end else if (clken) begin
      rdptr_r  <= rdptr_nxt_s;
      tail_r   <= tail_nxt_s;
      p_srdy_r <= p_srdy_nxt_s;
    end
  end

  assign rdptr_tail = tail_r;

endmodule

// File: tb/tb_sd_fifo_tail_small.sv
// Bench for sd_fifo_tail_small: a same-clock instance (async=0) and a
// Gray/synchronized instance (async=1) are driven side by side. The bench acts
// as the head block for each, and a count-based model (unbounded write/read
// counts plus an output-slot flag) predicts every output each cycle.
module tb_sd_fifo_tail_small;

  localparam int DEPTH = 16;
  localparam int ASZ   = 4;
  localparam int MOD   = 2 * DEPTH;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           clken = 1'b0;
  logic           p_drdy = 1'b0;
  logic [ASZ:0]   wh0 = '0, wh1 = '0;
  logic [ASZ:0]   tail0, tail1;
  logic           rd_en0, rd_en1;
  logic [ASZ-1:0] addr0, addr1;
  logic           srdy0, srdy1;
  logic [ASZ:0]   usage0, usage1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: writes issued, reads issued, output slot
  // occupied, and the two-stage delayed write count seen by the async side.
  int wc[2];
  int rc[2];
  int s1[2];
  int s2[2];
  bit slot[2];

  always #5 clk = ~clk;

  sd_fifo_tail_small #(.depth(DEPTH), .async(0)) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .wrptr_head(wh0),
    .rdptr_tail(tail0), .rd_en(rd_en0), .rd_addr(addr0),
    .p_srdy(srdy0), .p_drdy(p_drdy), .p_usage(usage0)
  );

  sd_fifo_tail_small #(.depth(DEPTH), .async(1)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .wrptr_head(wh1),
    .rdptr_tail(tail1), .rd_en(rd_en1), .rd_addr(addr1),
    .p_srdy(srdy1), .p_drdy(p_drdy), .p_usage(usage1)
  );

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Write count the read side can currently see.
  function automatic int eff(input int k);
    return (k == 0) ? wc[0] : s2[1];
  endfunction

  function automatic bit exp_rd_en(input int k);
    return clken && (eff(k) > rc[k]) && (p_drdy || !slot[k]);
  endfunction

  task automatic drive_heads();
    wh0 = 5'(wc[0] % MOD);
    wh1 = 5'(gray(wc[1] % MOD));
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int o_en, o_addr, o_srdy, o_use, o_tail, e_tail;
      o_en   = (k == 0) ? int'(rd_en0) : int'(rd_en1);
      o_addr = (k == 0) ? int'(addr0)  : int'(addr1);
      o_srdy = (k == 0) ? int'(srdy0)  : int'(srdy1);
      o_use  = (k == 0) ? int'(usage0) : int'(usage1);
      o_tail = (k == 0) ? int'(tail0)  : int'(tail1);
      e_tail = (k == 0) ? (rc[k] % MOD) : gray(rc[k] % MOD);
      check_value($sformatf("rd_en%0d", k), o_en, int'(exp_rd_en(k)));
      check_value($sformatf("rd_addr%0d", k), o_addr, rc[k] % DEPTH);
      check_value($sformatf("p_srdy%0d", k), o_srdy, int'(slot[k]));
      check_value($sformatf("p_usage%0d", k), o_use, eff(k) - rc[k]);
      check_value($sformatf("rdptr_tail%0d", k), o_tail, e_tail);
    end
  endtask

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_edge();
    bit en[2];
    for (int k = 0; k < 2; k++) en[k] = exp_rd_en(k);
    if (clken) begin
      for (int k = 0; k < 2; k++) begin
        if (en[k]) begin
          rc[k]++;
          slot[k] = 1'b1;
        end else if (p_drdy) begin
          slot[k] = 1'b0;
        end
        s2[k] = s1[k];
        s1[k] = wc[k];
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      wc[k] = 0; rc[k] = 0; s1[k] = 0; s2[k] = 0; slot[k] = 1'b0;
    end
  endtask

  // Called just after a negedge with inputs already set.
  task automatic run_cycle();
    drive_heads();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    check_value("rst_srdy0", int'(srdy0), 0);
    check_value("rst_srdy1", int'(srdy1), 0);
    check_value("rst_tail0", int'(tail0), 0);
    check_value("rst_tail1", int'(tail1), 0);
    model_clear();
    drive_heads();
    #1;
    check_value("rst_rd_en0", int'(rd_en0), 0);
    check_value("rst_usage0", int'(usage0), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int drdy_pct;
    model_clear();
    drive_heads();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_value("reset_rd_en", int'(rd_en0), 0);
    check_value("reset_srdy", int'(srdy0), 0);
    check_value("reset_usage", int'(usage0), 0);
    check_value("reset_tail", int'(tail0), 0);
    @(negedge clk);

    // Three words, consumer always ready: reads at addresses 0, 1, 2.
    clken = 1'b1;
    p_drdy = 1'b1;
    wc[0] = 3;
    for (int i = 0; i < 3; i++) begin
      drive_heads();
      #1;
      check_value("burst_rd_en", int'(rd_en0), 1);
      check_value("burst_addr", int'(addr0), i);
      check_value("burst_usage", int'(usage0), 3 - i);
      run_cycle();
    end
    #1;
    check_value("burst_tail", int'(tail0), 3);
    check_value("burst_srdy", int'(srdy0), 1);
    check_value("burst_done", int'(rd_en0), 0);
    run_cycle();
    run_cycle();

    // Randomized traffic: write bursts, consumer stalls, clock-enable gaps,
    // many pointer wraps, and one asynchronous reset in mid-stream.
    drdy_pct = 75;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) drdy_pct = $urandom_range(100, 0);
      clken  = ($urandom_range(9, 0) != 0);
      p_drdy = ($urandom_range(99, 0) < drdy_pct);
      for (int k = 0; k < 2; k++) begin
        int n;
        n = ($urandom_range(3, 0) == 0) ? $urandom_range(DEPTH, 0) : $urandom_range(1, 0);
        while (n > 0 && (wc[k] - rc[k]) < DEPTH) begin
          wc[k]++;
          n--;
        end
      end
      if (i == 2000) begin
        mid_reset();
      end else begin
        run_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
